regs_wb_arbiter: RTL

// - Shares the single register-file write port between the in-order pipeline writeback and the long-latency unit (mul/div).
// - Results from the long-latency (LU) unit are buffered in a small FIFO until they reach the port.
// - A 32-bit scoreboard tracks registers with LU writes outstanding and raises a decode hazard on them.
// - Sits between the writeback stage, the LU, and the regs write port (i_we/i_addr_wr/i_dat_wr).

---
 rtl/regs_wb_arbiter_pkg.sv | 15 +
 rtl/regs_wb_fifo.sv | 47 ++++
 rtl/regs_wb_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/regs_wb_arbiter_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
// Holds the arbiter FSM encoding and the LU result entry layout.
package regs_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;
    localparam int LU_ENTRY_W = REG_ADDR_W + XLEN;

    typedef enum logic {
        ARB_PIPE  = 1'b0,
        ARB_DRAIN = 1'b1
    } arb_state_e;

endpackage

// File: rtl/regs_wb_fifo.sv
// Synchronous FIFO buffering long-latency results as {addr,dat} entries.
// No bypass: a pushed entry is visible at the head from the next cycle.
module regs_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_ce,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_dout  = mem[rd_ptr[AW-1:0]];
    assign do_push = i_ce && i_push && !o_full;
    assign do_pop  = i_ce && i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push && !i_rst) mem[wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/regs_wb_arbiter.sv
// Shares the register-file write port between pipeline writeback and the LU FIFO,
// with a starvation-forced drain and a scoreboard driving the decode hazard.
module regs_wb_arbiter
    import regs_wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ce,
    input  logic                  i_wb_we,
    input  logic [REG_ADDR_W-1:0] i_wb_addr,
    input  logic [XLEN-1:0]       i_wb_dat,
    input  logic                  i_lu_issue,
    input  logic [REG_ADDR_W-1:0] i_lu_rd,
    input  logic                  i_lu_valid,
    output logic                  o_lu_ready,
    input  logic [REG_ADDR_W-1:0] i_lu_addr,
    input  logic [XLEN-1:0]       i_lu_dat,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic                  i_hz_rs1,
    input  logic                  i_hz_rs2,
    input  logic                  i_hz_rd,
    output logic                  o_hz_lu,
    output logic                  o_stall_pipe,
    output logic                  o_rf_we,
    output logic [REG_ADDR_W-1:0] o_rf_addr,
    output logic [XLEN-1:0]       o_rf_dat
);

    localparam int CNT_W = $clog2(STARVE_MAX) + 1;

    arb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      starve_q, starve_d;
    logic [NUM_REGS-1:0]   sb_q, sb_d;
    logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [REG_ADDR_W-1:0] head_addr;
    logic [XLEN-1:0]       head_dat;
    logic                  grant_pipe, grant_fifo;

    assign o_lu_ready = i_ce && !fifo_full;
    assign fifo_push  = i_lu_valid && o_lu_ready;
    assign fifo_pop   = i_ce && !i_rst && grant_fifo;

    regs_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (LU_ENTRY_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_ce    (i_ce),
        .i_push  (fifo_push),
        .i_pop   (fifo_pop),
        .i_din   ({i_lu_addr, i_lu_dat}),
        .o_dout  ({head_addr, head_dat}),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        grant_pipe   = 1'b0;
        grant_fifo   = 1'b0;
        o_stall_pipe = 1'b0;
        case (state_q)
            ARB_PIPE: begin
                if (i_wb_we) begin
                    grant_pipe = 1'b1;
                    if (fifo_empty) begin
                        starve_d = '0;
                    end else if (starve_q == CNT_W'(STARVE_MAX - 1)) begin
                        state_d  = ARB_DRAIN;
                        starve_d = '0;
                    end else begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end else begin
                    grant_fifo = !fifo_empty;
                    starve_d   = '0;
                end
            end
            ARB_DRAIN: begin
                // Pipeline holds its write and re-presents it next cycle.
                o_stall_pipe = 1'b1;
                grant_fifo   = !fifo_empty;
                state_d      = ARB_PIPE;
                starve_d     = '0;
            end
            default: begin
                state_d  = ARB_PIPE;
                starve_d = '0;
            end
        endcase
    end

    always_comb begin
        if (grant_pipe) begin
            o_rf_addr = i_wb_addr;
            o_rf_dat  = i_wb_dat;
        end else begin
            o_rf_addr = head_addr;
            o_rf_dat  = head_dat;
        end
        o_rf_we = !i_rst && (grant_pipe || grant_fifo) && (o_rf_addr != '0);
    end

    // Issue is applied after the pop clear so a same-register set wins.
    always_comb begin
        sb_d = sb_q;
        if (fifo_pop) sb_d[head_addr] = 1'b0;
        if (i_ce && i_lu_issue && (i_lu_rd != '0)) sb_d[i_lu_rd] = 1'b1;
        sb_d[0] = 1'b0;
    end

    assign o_hz_lu = (i_hz_rs1 && (i_rs1 != '0) && sb_q[i_rs1])
                  || (i_hz_rs2 && (i_rs2 != '0) && sb_q[i_rs2])
                  || (i_hz_rd  && (i_rd  != '0) && sb_q[i_rd]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ARB_PIPE;
            starve_q <= '0;
            sb_q     <= '0;
        end else if (i_ce) begin
            state_q  <= state_d;
            starve_q <= starve_d;
            sb_q     <= sb_d;
        end
    end

endmodule
